// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing block: default 640x480@60 timing
// and the frame-time type handed to animation consumers.
package vga_pkg;

  localparam int DEF_HACTIVE = 640;
  localparam int DEF_HFRONT  = 16;
  localparam int DEF_HSYNC   = 96;
  localparam int DEF_HBACK   = 48;
  localparam int DEF_VACTIVE = 480;
  localparam int DEF_VFRONT  = 10;
  localparam int DEF_VSYNC   = 2;
  localparam int DEF_VBACK   = 33;

  typedef logic [7:0] vga_time_t;

  // One extra bit over the total so the blanking span fits as negative values.
  function automatic int axis_width(input int total);
    return $clog2(total) + 1;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Video timing bundle: scan position, syncs, blanking and frame-time outputs.
interface vga_timing_if #(
  parameter int HW = 11,
  parameter int VW = 11
);
  import vga_pkg::*;

  logic signed [HW-1:0] counter_h;
  logic signed [VW-1:0] counter_v;
  vga_time_t            cur_time;
  logic                 hsync;
  logic                 vsync;
  logic                 display_on;
  logic                 line_end;
  logic                 frame_end;

  modport master (
    output counter_h, counter_v, cur_time, hsync, vsync,
           display_on, line_end, frame_end
  );

  modport slave (
    input  counter_h, counter_v, cur_time, hsync, vsync,
           display_on, line_end, frame_end
  );
endinterface

// File: rtl/vga_timing_axis.sv
// One scan axis: signed counter from -BLANK to ACTIVE-1 with a registered,
// active-low sync flag that tracks the counter value it describes.
module timing_axis #(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48,
  parameter int W      = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic signed [W-1:0] cnt,
  output logic signed [W-1:0] cnt_nxt,
  output logic                wrap,
  output logic                sync_n
);
  localparam int BLANK = FRONT + SYNC + BACK;

  localparam logic signed [W-1:0] START      = W'(-BLANK);
  localparam logic signed [W-1:0] LAST       = W'(ACTIVE - 1);
  localparam logic signed [W-1:0] SYNC_FIRST = W'(FRONT - BLANK);
  localparam logic signed [W-1:0] SYNC_LAST  = W'(-BACK - 1);
  localparam logic signed [W-1:0] ONE        = W'(1);

  assign wrap = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (en) cnt_nxt = wrap ? START : cnt + ONE;
  end

  // Sync is decoded from the next count so the flop lands aligned with cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= START;
      sync_n <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      sync_n <= !((cnt_nxt >= SYNC_FIRST) && (cnt_nxt <= SYNC_LAST));
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator. Optional macro VGA_TIME_FREEZE_EN adds a
// time_freeze input that stalls the frame-time counter at frame end.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HACTIVE = DEF_HACTIVE,
  parameter int HFRONT  = DEF_HFRONT,
  parameter int HSYNC   = DEF_HSYNC,
  parameter int HBACK   = DEF_HBACK,
  parameter int VACTIVE = DEF_VACTIVE,
  parameter int VFRONT  = DEF_VFRONT,
  parameter int VSYNC   = DEF_VSYNC,
  parameter int VBACK   = DEF_VBACK
) (
  input  logic clk,
  input  logic rst_n,
`ifdef VGA_TIME_FREEZE_EN
  input  logic time_freeze,
`endif
  vga_timing_if.master vga
);
  localparam int HBLANK = HFRONT + HSYNC + HBACK;
  localparam int HTOTAL = HACTIVE + HBLANK;
  localparam int VBLANK = VFRONT + VSYNC + VBACK;
  localparam int VTOTAL = VACTIVE + VBLANK;
  localparam int HW     = axis_width(HTOTAL);
  localparam int VW     = axis_width(VTOTAL);

  logic signed [HW-1:0] h_cnt, h_nxt;
  logic signed [VW-1:0] v_cnt, v_nxt;
  logic                 h_wrap, v_wrap, h_sync_n, v_sync_n;
  logic                 display_on_r, frame_end, time_hold;
  vga_time_t            cur_time_r;

  timing_axis #(
    .ACTIVE(HACTIVE), .FRONT(HFRONT), .SYNC(HSYNC), .BACK(HBACK), .W(HW)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .cnt(h_cnt), .cnt_nxt(h_nxt), .wrap(h_wrap), .sync_n(h_sync_n)
  );

  timing_axis #(
    .ACTIVE(VACTIVE), .FRONT(VFRONT), .SYNC(VSYNC), .BACK(VBACK), .W(VW)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .en(h_wrap),
    .cnt(v_cnt), .cnt_nxt(v_nxt), .wrap(v_wrap), .sync_n(v_sync_n)
  );

  assign frame_end = h_wrap && v_wrap;

`ifdef VGA_TIME_FREEZE_EN
  assign time_hold = time_freeze;
`else
  assign time_hold = 1'b0;
`endif

  // Visible when both next positions are non-negative, i.e. sign bits clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_on_r <= 1'b0;
      cur_time_r   <= '0;
    end else begin
      display_on_r <= !h_nxt[HW-1] && !v_nxt[VW-1];
      if (frame_end && !time_hold) cur_time_r <= cur_time_r + 8'd1;
    end
  end

  assign vga.counter_h  = h_cnt;
  assign vga.counter_v  = v_cnt;
  assign vga.cur_time   = cur_time_r;
  assign vga.hsync      = h_sync_n;
  assign vga.vsync      = v_sync_n;
  assign vga.display_on = display_on_r;
  assign vga.line_end   = h_wrap;
  assign vga.frame_end  = frame_end;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a reduced-size instance for full-frame
// behaviour and a default 640x480 instance for the reference timing numbers.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int SHA = 8, SHF = 2, SHS = 3, SHBK = 2;
  localparam int SVA = 4, SVF = 1, SVS = 2, SVBK = 1;
  localparam int SHB = SHF + SHS + SHBK;
  localparam int SHT = SHA + SHB;
  localparam int SVB = SVF + SVS + SVBK;
  localparam int SVT = SVA + SVB;
  localparam int SFR = SHT * SVT;
  localparam int SHW = $clog2(SHT) + 1;
  localparam int SVW = $clog2(SVT) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_s = 1'b0;
  logic rst_n_d = 1'b0;
`ifdef VGA_TIME_FREEZE_EN
  logic tf_s = 1'b0;
  logic tf_d = 1'b0;
`endif

  vga_timing_if #(.HW(SHW), .VW(SVW)) vif_s ();
  vga_timing_if #(.HW(11), .VW(11))   vif_d ();

  vga_timing #(
    .HACTIVE(SHA), .HFRONT(SHF), .HSYNC(SHS), .HBACK(SHBK),
    .VACTIVE(SVA), .VFRONT(SVF), .VSYNC(SVS), .VBACK(SVBK)
  ) dut_s (
    .clk(clk), .rst_n(rst_n_s),
`ifdef VGA_TIME_FREEZE_EN
    .time_freeze(tf_s),
`endif
    .vga(vif_s)
  );

  vga_timing dut_d (
    .clk(clk), .rst_n(rst_n_d),
`ifdef VGA_TIME_FREEZE_EN
    .time_freeze(tf_d),
`endif
    .vga(vif_d)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int   h;
    int   v;
    logic hs, vs, de, le, fe;
  } exp_t;

  typedef struct packed {
    int   n;
    int   t;
    exp_t e;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected outputs n clocks after reset release, from the raster geometry.
  function automatic exp_t model(input int n);
    exp_t e;
    int pos  = n % SHT;
    int line = (n / SHT) % SVT;
    e.h  = pos - SHB;
    e.v  = line - SVB;
    e.hs = !((e.h >= SHF - SHB) && (e.h < -SHBK));
    e.vs = !((e.v >= SVF - SVB) && (e.v < -SVBK));
    e.de = (e.h >= 0) && (e.v >= 0);
    e.le = (e.h == SHA - 1);
    e.fe = e.le && (e.v == SVA - 1);
    return e;
  endfunction

  task automatic check_s(input string tag, input exp_t e, input int t);
    chk({tag, " counter_h"},  vif_s.counter_h,  e.h);
    chk({tag, " counter_v"},  vif_s.counter_v,  e.v);
    chk({tag, " hsync"},      vif_s.hsync,      e.hs);
    chk({tag, " vsync"},      vif_s.vsync,      e.vs);
    chk({tag, " display_on"}, vif_s.display_on, e.de);
    chk({tag, " line_end"},   vif_s.line_end,   e.le);
    chk({tag, " frame_end"},  vif_s.frame_end,  e.fe);
    chk({tag, " cur_time"},   vif_s.cur_time,   t);
  endtask

  task automatic add_vec(input int n, input int h, input int v,
                         input logic hs, input logic vs, input logic de,
                         input logic le, input logic fe, input int t);
    vec_t r;
    r.n = n; r.t = t;
    r.e.h = h; r.e.v = v;
    r.e.hs = hs; r.e.vs = vs; r.e.de = de; r.e.le = le; r.e.fe = fe;
    tbl.push_back(r);
  endtask

  task automatic reset_s();
    rst_n_s = 1'b0;
    step();
    rst_n_s = 1'b1;
  endtask

  initial begin
    int   n, t;
    exp_t e, e_prev;
    logic fr;

    //        n    h   v  hs vs de le fe  t
    add_vec(  0,  -7, -4, 1, 1, 0, 0, 0, 0);
    add_vec(  1,  -6, -4, 1, 1, 0, 0, 0, 0);
    add_vec(  2,  -5, -4, 0, 1, 0, 0, 0, 0);
    add_vec(  4,  -3, -4, 0, 1, 0, 0, 0, 0);
    add_vec(  5,  -2, -4, 1, 1, 0, 0, 0, 0);
    add_vec( 14,   7, -4, 1, 1, 0, 1, 0, 0);
    add_vec( 15,  -7, -3, 1, 0, 0, 0, 0, 0);
    add_vec( 32,  -5, -2, 0, 0, 0, 0, 0, 0);
    add_vec( 45,  -7, -1, 1, 1, 0, 0, 0, 0);
    add_vec( 67,   0,  0, 1, 1, 1, 0, 0, 0);
    add_vec( 74,   7,  0, 1, 1, 1, 1, 0, 0);
    add_vec(119,   7,  3, 1, 1, 1, 1, 1, 0);
    add_vec(120,  -7, -4, 1, 1, 0, 0, 0, 1);

    // Table walk from reset; entry 0 is the in-reset state.
    rst_n_s = 1'b0;
    step();
    check_s("vec0", tbl[0].e, tbl[0].t);
    rst_n_s = 1'b1;
    n = 0;
    for (int i = 1; i < tbl.size(); i++) begin
      while (n < tbl[i].n) begin
        step();
        n++;
      end
      check_s($sformatf("vec%0d", i), tbl[i].e, tbl[i].t);
    end

    // Mid-frame reset at h=3, v=2: next edge restores reset state, no pulses.
    while (n < SFR + 100) begin
      step();
      n++;
    end
    chk("midrst pre h", vif_s.counter_h, 3);
    chk("midrst pre v", vif_s.counter_v, 2);
    rst_n_s = 1'b0;
    step();
    check_s("midrst", tbl[0].e, 0);
    step();
    chk("midrst hold line_end", vif_s.line_end, 0);
    chk("midrst hold frame_end", vif_s.frame_end, 0);
    rst_n_s = 1'b1;
    step();
    chk("midrst release h", vif_s.counter_h, -SHB + 1);

    // Line/frame periods, vsync width and visible pixels per line.
    begin
      int fe_prev = -1, fe_gap = -1, le_prev = -1, le_gap = -1;
      int vs_low = 0, vs_bad = 0, de_line = 0;
      logic in_vs;
      reset_s();
      for (int k = 1; k <= 2 * SFR + 5; k++) begin
        step();
        if (vif_s.frame_end) begin
          if (fe_prev >= 0 && fe_gap < 0) fe_gap = k - fe_prev;
          fe_prev = k;
        end
        if (vif_s.line_end) begin
          if (le_prev >= 0 && le_gap < 0) le_gap = k - le_prev;
          le_prev = k;
        end
        in_vs = (vif_s.counter_v >= SVF - SVB) && (vif_s.counter_v < -SVBK);
        if (vif_s.vsync === in_vs) vs_bad++;
        if (k < SFR) begin
          if (!vif_s.vsync) vs_low++;
          if (vif_s.counter_v == 1 && vif_s.display_on) de_line++;
        end
      end
      chk("frame_end period", fe_gap, SFR);
      chk("line_end period", le_gap, SHT);
      chk("vsync low clocks", vs_low, SVS * SHT);
      chk("vsync region misalign", vs_bad, 0);
      chk("display_on per line", de_line, SHA);
    end

    // 256 frames: cur_time walks 0..255 then wraps to 0.
    begin
      logic saw255 = 1'b0;
      reset_s();
      n = 0;
      for (int k = 1; k <= 256 * SFR + 1; k++) begin
        step();
        n++;
        if (vif_s.cur_time == 8'd255) saw255 = 1'b1;
        check_s("run", model(n), (n / SFR) % 256);
      end
      chk("time reached 255", saw255, 1);
      chk("time wrapped", vif_s.cur_time, 0);
    end

    // Random resets (and freeze when present) against the reference model.
    reset_s();
    n = 0;
    t = 0;
    for (int k = 0; k < 4000; k++) begin
      rst_n_s = ($urandom_range(0, 499) != 0);
`ifdef VGA_TIME_FREEZE_EN
      tf_s = 1'($urandom_range(0, 1));
      fr = tf_s;
`else
      fr = 1'b0;
`endif
      e_prev = model(n);
      step();
      if (!rst_n_s) begin
        n = 0;
        t = 0;
      end else begin
        if (e_prev.fe && !fr) t = (t + 1) % 256;
        n++;
      end
      check_s("rand", model(n), t);
    end
    rst_n_s = 1'b1;

`ifdef VGA_TIME_FREEZE_EN
    // Freeze across the frame_end at cur_time=7, then one normal frame.
    tf_s = 1'b0;
    reset_s();
    for (int k = 0; k < 7 * SFR; k++) step();
    chk("freeze start time", vif_s.cur_time, 7);
    tf_s = 1'b1;
    for (int k = 0; k < SFR; k++) step();
    chk("frozen time", vif_s.cur_time, 7);
    chk("frozen counter_h", vif_s.counter_h, -SHB);
    chk("frozen counter_v", vif_s.counter_v, -SVB);
    tf_s = 1'b0;
    for (int k = 0; k < SFR; k++) step();
    chk("unfrozen time", vif_s.cur_time, 8);
`endif

    // Default 640x480 instance: reset values, hsync edges, line period.
    begin
      int fall_h = 9999, rise_h = 9999, le1 = -1, le2 = -1;
      logic hs_prev;
      rst_n_d = 1'b0;
      step();
      chk("def reset counter_h", vif_d.counter_h, -160);
      chk("def reset counter_v", vif_d.counter_v, -45);
      chk("def reset hsync", vif_d.hsync, 1);
      chk("def reset vsync", vif_d.vsync, 1);
      chk("def reset display_on", vif_d.display_on, 0);
      chk("def reset cur_time", vif_d.cur_time, 0);
      rst_n_d = 1'b1;
      step();
      chk("def first edge counter_h", vif_d.counter_h, -159);
      hs_prev = vif_d.hsync;
      for (int k = 2; k <= 2000; k++) begin
        step();
        if (hs_prev && !vif_d.hsync && fall_h == 9999) fall_h = int'(vif_d.counter_h);
        if (!hs_prev && vif_d.hsync && fall_h != 9999 && rise_h == 9999)
          rise_h = int'(vif_d.counter_h);
        hs_prev = vif_d.hsync;
        if (vif_d.line_end) begin
          if (le1 < 0) le1 = k;
          else if (le2 < 0) le2 = k;
        end
      end
      chk("def hsync fall at", fall_h, -144);
      chk("def hsync rise at", rise_h, -48);
      chk("def first line_end", le1, 799);
      chk("def line period", le2 - le1, 800);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter HACTIVE, 640, visible pixels per line.
REQ-002 Parameter HFRONT, 16, horizontal front porch, in pixels.
REQ-003 Parameter HSYNC, 96, horizontal sync width, in pixels.
REQ-004 Parameter HBACK, 48, horizontal back porch, in pixels.
REQ-005 Parameter VACTIVE, 480, visible lines per frame.
REQ-006 Parameter VFRONT, 10, vertical front porch, in lines.
REQ-007 Parameter VSYNC, 2, vertical sync width, in lines.
REQ-008 Parameter VBACK, 33, vertical back porch, in lines.
REQ-009 Derived values SHALL be: HBLANK=HFRONT+HSYNC+HBACK, HTOTAL=HACTIVE+HBLANK, VBLANK=VFRONT+VSYNC+VBACK, VTOTAL=VACTIVE+VBLANK.
REQ-010 clk  in  1  single system/pixel clock; all logic on the rising edge.
REQ-011 rst_n  in  1  reset, synchronous, active-low.
REQ-012 counter_h  out  signed $clog2(HTOTAL)+1  horizontal position; 0..HACTIVE-1 is visible.
REQ-013 counter_v  out  signed $clog2(VTOTAL)+1  vertical position; 0..VACTIVE-1 is visible.
REQ-014 cur_time  out  8  frame counter, used by consumers for animation.
REQ-015 hsync  out  1  horizontal sync, active-low.
REQ-016 vsync  out  1  vertical sync, active-low.
REQ-017 display_on  out  1  high iff counter_h>=0 and counter_v>=0.
REQ-018 line_end  out  1  one-cycle pulse while counter_h==HACTIVE-1, on every line including blank lines.
REQ-019 frame_end  out  1  one-cycle pulse while counter_h==HACTIVE-1 and counter_v==VACTIVE-1.

Function
REQ-020 counter_h SHALL count -HBLANK..HACTIVE-1, incrementing by 1 each clock; after HACTIVE-1 it SHALL wrap to -HBLANK.
REQ-021 counter_v SHALL increment only on the edge where counter_h wraps; after VACTIVE-1 it SHALL wrap to -VBLANK.
REQ-022 Horizontal blanking regions SHALL be ordered as: front porch -HBLANK..-HBLANK+HFRONT-1, then sync, then back porch -HBACK..-1. Vertical blanking SHALL use the same ordering.
REQ-023 hsync SHALL be 0 exactly while counter_h lies in the sync region; vsync SHALL be 0 exactly while counter_v lies in its sync region, for the whole line.
REQ-024 hsync, vsync and display_on SHALL be registered and aligned with the counter values they describe (zero-cycle skew).
REQ-025 cur_time SHALL increment by 1 on the clock edge that leaves the frame_end cycle, and SHALL wrap from 255 to 0.
REQ-026 line_end and frame_end SHALL be pure decodes of the registered counters, with no additional latency.
REQ-027 Counter arithmetic SHALL be signed at the declared width; no overflow is possible for legal parameters.

Reset
REQ-028 While rst_n=0 at a clock edge: counter_h=-HBLANK, counter_v=-VBLANK, cur_time=0, hsync=1, vsync=1, display_on=0, line_end=0, frame_end=0.
REQ-029 Reset asserted mid-frame SHALL restore these values on the next edge; no partial line or frame pulse SHALL follow.
REQ-030 The first clock edge after release SHALL advance counter_h to -HBLANK+1.

Configuration
REQ-031 Macro VGA_TIME_FREEZE_EN defined: the block SHALL add input time_freeze (1 bit); when time_freeze=1 during the frame_end cycle, cur_time SHALL hold its value. Counters and syncs are unaffected.
REQ-032 Macro undefined: the time_freeze port SHALL be absent, and cur_time SHALL increment every frame.

Structure
REQ-033 Package vga_pkg SHALL hold the default 640x480 timing localparams and a typedef for the 8-bit time value.
REQ-034 One sub-module, timing_axis, SHALL be instantiated twice (horizontal and vertical): a wrapping signed counter with an enable input, a wrap output and a sync-region output.

Verification
REQ-035 Release reset -> counter_h=-160, counter_v=-45; hsync first falls when counter_h=-144 and rises when counter_h=-48.
REQ-036 Run one line -> exactly 800 clocks between consecutive line_end pulses; display_on high for exactly 640 of them when counter_v>=0.
REQ-037 Run one frame -> 420000 clocks between frame_end pulses; vsync low for exactly 1600 clocks, while counter_v is -35..-34.
REQ-038 Run 256 frames -> cur_time goes 0..255 and then reads 0.
REQ-039 Assert rst_n=0 at counter_h=100, counter_v=200 -> the next edge gives the REQ-028 values, with no line_end or frame_end pulse.
REQ-040 With VGA_TIME_FREEZE_EN, hold time_freeze=1 across frame_end at cur_time=7 -> cur_time stays 7; the following unfrozen frame gives 8.
